replay_buffer_p: RTL and testbench
==================================

Name: replay_buffer_p

Overview:
- Parametrised successor to the single-width DLL replay buffer.
- Retains copies of transmitted TLP words tagged with sequence numbers, with one word per entry.
- Purges entries on ACK, and replays every unacknowledged entry in order on NAK or replay-timer expiry.
- Sits between the TLP transmit path and the link arbiter; tracks REPLAY_NUM and flags rollover to the LTSSM.

Parameters:
DATA_W, 16, width of each stored TLP word
DEPTH, 16, number of entries (power of 2, DEPTH < 2**SEQ_W)
SEQ_W, 12, sequence number width
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock; everything is sampled on the rising edge
rst  in  1  synchronous, active-high reset
we  in  1  write request (a TLP word is being transmitted)
din  in  DATA_W  word to retain
wr_ready  out  1  buffer accepts a write (not full, not replaying)
wr_seq  out  SEQ_W  sequence number that the next accepted write receives
ack_nack  in  2  00 none, 01 ACK, 10 NAK, 11 reserved (ignored)
ack_seq  in  SEQ_W  AckNak_Seq_Num of the DLLP
tim_out  in  1  replay-timer expiry pulse
busy_n  in  1  link free; a replay word advances only when this is 1
rp_valid  out  1  replay word presented
rp_data  out  DATA_W  replay word
rp_seq  out  SEQ_W  sequence number of the replay word
replaying  out  1  in REPLAY state
count  out  AW+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0
rollover  out  1  one-cycle pulse: REPLAY_NUM rollover
seq_err  out  1  one-cycle pulse: ACK/NAK seq outside outstanding range

Behaviour:
- Reset values:
  - Pointers, count, wr_seq, head_seq, REPLAY_NUM all 0.
  - State IDLE.
  - rp_valid, replaying, rollover, seq_err all 0; empty=1; wr_ready=1.
- Write:
  - Accepted when we && wr_ready.
  - Stores {din, wr_seq} at tail; tail++ (mod DEPTH); wr_seq++ (mod 2**SEQ_W); count++.
  - No-op when not accepted; a dropped write is the caller's error.
- ACK/NAK decode:
  - d = (ack_seq - head_seq + 1) mod 2**SEQ_W.
  - Valid iff d <= count; d=0 means nothing new acknowledged.
  - Invalid: ignore the DLLP and pulse seq_err next cycle.
- Purge (valid ACK or NAK):
  - head += d; head_seq += d; count -= d, all in a single cycle.
  - If d>0, REPLAY_NUM clears to 0.
- Replay start:
  - Triggered by a valid NAK or by tim_out, evaluated after the same-cycle purge.
  - If the remaining count is 0: no replay, REPLAY_NUM unchanged.
  - Else if REPLAY_NUM == 3: pulse rollover, REPLAY_NUM cleared to 0, no replay.
  - Else REPLAY_NUM++, rp_ptr = head, enter REPLAY next cycle.
  - NAK and tim_out in the same cycle produce one replay and one increment.
- State machine:
  - IDLE -> REPLAY on replay start.
  - REPLAY -> IDLE when the word at tail-1 is taken (rp_valid && busy_n).
  - REPLAY -> IDLE when the remaining count reaches 0.
- REPLAY behaviour:
  - rp_valid = 1; rp_data/rp_seq combinationally read from rp_ptr.
  - rp_ptr++ when busy_n=1, giving 1 word/cycle; the word holds while busy_n=0.
  - wr_ready = 0.
- ACK during REPLAY:
  - Purges normally.
  - If the new head has passed rp_ptr, rp_ptr snaps to the new head.
  - If the buffer empties, return to IDLE.
- NAK or tim_out during REPLAY: purge only; the replay is not restarted or counted.
- Sequence number wrap is mod 2**SEQ_W throughout. Pointers wrap mod DEPTH.
- rst mid-replay: every register returns to its reset value and the contents are discarded.

Decomposition:
- Package rb_pkg holds:
  - ack_nack codes: AN_NONE, AN_ACK, AN_NAK.
  - State enum {RB_IDLE, RB_REPLAY}.
  - REPLAY_NUM_MAX = 3.
- Sub-module rb_mem: DEPTH x (DATA_W+SEQ_W) simple dual-port RAM.
  - Synchronous write, asynchronous read.
  - Replaces the old fixed mem1 FIFO.

Test Plan:
1. Write 5 words (0xA000..0xA004) -> wr_seq=5, count=5. ACK seq=2 -> count=2, head_seq=3, REPLAY_NUM=0.
2. Fill 16 words -> full=1, wr_ready=0. A 17th we is dropped and count stays 16. ACK seq=15 -> empty=1.
3. 4 words outstanding, NAK seq=0 -> purge 1, replay seq 1,2,3 on consecutive cycles with busy_n=1. Then drop busy_n for 2 cycles mid-replay -> rp_data held.
4. Four tim_out with no ACK and 2 words outstanding -> three replays, then rollover pulse with no replay, REPLAY_NUM=0.
5. ACK seq=9 with head_seq=2 and count=3 -> seq_err pulse, state unchanged. Also set wr_seq near 4095 and confirm wrap to 0 and a correct ACK across the wrap.
6. ACK seq past rp_ptr during replay -> rp_ptr jumps to head. Assert rst mid-replay -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared definitions for the parametrised DLL replay buffer.
package rb_pkg;

    // DLLP acknowledge codes presented on ack_nack
    typedef enum logic [1:0] {
        AN_NONE = 2'b00,
        AN_ACK  = 2'b01,
        AN_NAK  = 2'b10,
        AN_RSVD = 2'b11
    } an_code_e;

    // Replay controller states
    typedef enum logic {
        RB_IDLE,
        RB_REPLAY
    } rb_state_e;

    // Replay attempts allowed before a rollover is reported to the LTSSM
    localparam logic [1:0] REPLAY_NUM_MAX = 2'd3;

endpackage

// File: rtl/rb_mem.sv
// Replay storage: simple dual-port RAM, synchronous write, asynchronous read.
module rb_mem #(
    parameter int W     = 28,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Store one {data, seq} entry per accepted write; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/replay_buffer_p.sv
// DLL replay buffer: retains transmitted TLP words with their sequence
// numbers, purges on ACK/NAK and replays all outstanding words on NAK or
// replay-timer expiry, tracking REPLAY_NUM and reporting rollover.
module replay_buffer_p
    import rb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 12,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic              wr_ready,
    output logic [SEQ_W-1:0]  wr_seq,
    input  logic [1:0]        ack_nack,
    input  logic [SEQ_W-1:0]  ack_seq,
    input  logic              tim_out,
    input  logic              busy_n,
    output logic              rp_valid,
    output logic [DATA_W-1:0] rp_data,
    output logic [SEQ_W-1:0]  rp_seq,
    output logic              replaying,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              rollover,
    output logic              seq_err
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    rb_state_e        state_q, state_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW-1:0]    rp_ptr_q, rp_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [SEQ_W-1:0] wr_seq_q, wr_seq_d;
    logic [SEQ_W-1:0] head_seq_q, head_seq_d;
    logic [1:0]       replay_num_q, replay_num_d;
    logic             rollover_q, rollover_d;
    logic             seq_err_q, seq_err_d;

    logic                    wr_acc;
    logic                    is_ack, is_nak, an_hit, an_ok;
    logic [SEQ_W-1:0]        an_dist;
    logic [AW:0]             purge;
    logic [AW:0]             remain;
    logic [AW-1:0]           rp_off_base;
    logic [AW:0]             rp_off;
    logic [DATA_W+SEQ_W-1:0] rd_word;

    assign wr_ready = (state_q == RB_IDLE) && (count_q != CNT_FULL);
    assign wr_acc   = we && wr_ready;

    // Distance from the oldest outstanding entry; 0 means nothing new acked
    assign is_ack  = (ack_nack == AN_ACK);
    assign is_nak  = (ack_nack == AN_NAK);
    assign an_hit  = is_ack || is_nak;
    assign an_dist = ack_seq - head_seq_q + SEQ_W'(1);
    assign an_ok   = (an_dist <= SEQ_W'(count_q));
    assign purge   = (an_hit && an_ok) ? (AW+1)'(an_dist) : '0;
    assign remain  = count_q - purge;

    // Offset (from the pre-purge head) of the word the replay presents next
    assign rp_off_base = rp_ptr_q - head_q;
    assign rp_off      = (AW+1)'(rp_off_base) + (AW+1)'(busy_n);

    rb_mem #(
        .W     (DATA_W + SEQ_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (tail_q),
        .wdata_i ({din, wr_seq_q}),
        .raddr_i (rp_ptr_q),
        .rdata_o (rd_word)
    );

    // Next-state: write, purge, replay start/advance and REPLAY_NUM tracking
    always_comb begin
        state_d      = state_q;
        head_d       = head_q + AW'(purge);
        head_seq_d   = head_seq_q + SEQ_W'(purge);
        tail_d       = tail_q;
        wr_seq_d     = wr_seq_q;
        rp_ptr_d     = rp_ptr_q;
        count_d      = remain + (AW+1)'(wr_acc);
        replay_num_d = replay_num_q;
        rollover_d   = 1'b0;
        seq_err_d    = an_hit && !an_ok;

        if (purge != '0) begin
            replay_num_d = '0;
        end

        if (wr_acc) begin
            tail_d   = tail_q + PTR_ONE;
            wr_seq_d = wr_seq_q + SEQ_W'(1);
        end

        case (state_q)
            RB_IDLE: begin
                if (((is_nak && an_ok) || tim_out) && (remain != '0)) begin
                    if (replay_num_d == REPLAY_NUM_MAX) begin
                        rollover_d   = 1'b1;
                        replay_num_d = '0;
                    end else begin
                        replay_num_d = replay_num_d + 2'd1;
                        rp_ptr_d     = head_d;
                        state_d      = RB_REPLAY;
                    end
                end
            end
            RB_REPLAY: begin
                if (rp_off < purge) begin
                    rp_ptr_d = head_d;
                end else begin
                    rp_ptr_d = rp_ptr_q + AW'(busy_n);
                end
                if ((busy_n && (rp_ptr_q == tail_q - PTR_ONE)) || (remain == '0)) begin
                    state_d = RB_IDLE;
                end
            end
            default: state_d = RB_IDLE;
        endcase
    end

    // State and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RB_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            rp_ptr_q     <= '0;
            count_q      <= '0;
            wr_seq_q     <= '0;
            head_seq_q   <= '0;
            replay_num_q <= '0;
            rollover_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            rp_ptr_q     <= rp_ptr_d;
            count_q      <= count_d;
            wr_seq_q     <= wr_seq_d;
            head_seq_q   <= head_seq_d;
            replay_num_q <= replay_num_d;
            rollover_q   <= rollover_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign replaying = (state_q == RB_REPLAY);
    assign rp_valid  = replaying;
    assign rp_data   = rd_word[DATA_W+SEQ_W-1:SEQ_W];
    assign rp_seq    = rd_word[SEQ_W-1:0];
    assign wr_seq    = wr_seq_q;
    assign count     = count_q;
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign rollover  = rollover_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_replay_buffer_p.sv
// Directed self-checking bench for replay_buffer_p.
module tb_replay_buffer_p;

    logic        clk = 1'b0;
    logic        rst, we, tim_out, busy_n;
    logic [15:0] din;
    logic [1:0]  ack_nack;
    logic [11:0] ack_seq;
    logic        wr_ready, rp_valid, replaying, full, empty, rollover, seq_err;
    logic [11:0] wr_seq, rp_seq;
    logic [15:0] rp_data;
    logic [4:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    replay_buffer_p dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .din       (din),
        .wr_ready  (wr_ready),
        .wr_seq    (wr_seq),
        .ack_nack  (ack_nack),
        .ack_seq   (ack_seq),
        .tim_out   (tim_out),
        .busy_n    (busy_n),
        .rp_valid  (rp_valid),
        .rp_data   (rp_data),
        .rp_seq    (rp_seq),
        .replaying (replaying),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .rollover  (rollover),
        .seq_err   (seq_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0; din = '0; ack_nack = 2'b00; ack_seq = '0;
        tim_out = 1'b0; busy_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] d);
        we = 1'b1; din = d;
        tick();
        we = 1'b0;
    endtask

    task automatic send_dllp(input logic [1:0] code, input logic [11:0] s);
        ack_nack = code; ack_seq = s;
        tick();
        ack_nack = 2'b00;
    endtask

    task automatic pulse_timer();
        tim_out = 1'b1;
        tick();
        tim_out = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", full); end
        n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready got %b want 1", wr_ready); end
        n_tests++; if (wr_seq !== 12'd0) begin n_fail++; $display("FAIL rst_wr_seq got %0d want 0", wr_seq); end
        n_tests++; if (rp_valid !== 1'b0 || replaying !== 1'b0) begin n_fail++; $display("FAIL rst_replay got %b%b want 00", rp_valid, replaying); end
        n_tests++; if (rollover !== 1'b0 || seq_err !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got %b%b want 00", rollover, seq_err); end
    endtask

    task automatic test_ack_purge();
        do_reset();
        for (int i = 0; i < 5; i++) write_word(16'hA000 + 16'(i));
        n_tests++; if (wr_seq !== 12'd5) begin n_fail++; $display("FAIL ack_wr_seq got %0d want 5", wr_seq); end
        n_tests++; if (count !== 5'd5) begin n_fail++; $display("FAIL ack_count5 got %0d want 5", count); end
        send_dllp(2'b01, 12'd2);
        n_tests++; if (count !== 5'd2) begin n_fail++; $display("FAIL ack_count2 got %0d want 2", count); end
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL ack_no_err got %b want 0", seq_err); end
        // head_seq is now 3: re-acking 2 is a valid no-op, acking 1 is out of range
        send_dllp(2'b01, 12'd2);
        n_tests++; if (count !== 5'd2 || seq_err !== 1'b0) begin n_fail++; $display("FAIL ack_dup got count=%0d err=%b want 2/0", count, seq_err); end
        send_dllp(2'b01, 12'd1);
        n_tests++; if (count !== 5'd2 || seq_err !== 1'b1) begin n_fail++; $display("FAIL ack_stale got count=%0d err=%b want 2/1", count, seq_err); end
        tick();
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL ack_err_pulse got %b want 0", seq_err); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) write_word(16'h1000 + 16'(i));
        n_tests++; if (full !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags got full=%b rdy=%b want 1/0", full, wr_ready); end
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", count); end
        write_word(16'hDEAD);
        n_tests++; if (count !== 5'd16 || wr_seq !== 12'd16) begin n_fail++; $display("FAIL full_drop got count=%0d seq=%0d want 16/16", count, wr_seq); end
        send_dllp(2'b01, 12'd15);
        n_tests++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL full_empty got empty=%b count=%0d want 1/0", empty, count); end
        n_tests++; if (full !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_release got full=%b rdy=%b want 0/1", full, wr_ready); end
    endtask

    task automatic test_nak_replay();
        do_reset();
        for (int i = 0; i < 4; i++) write_word(16'hB000 + 16'(i));
        busy_n = 1'b1;
        send_dllp(2'b10, 12'd0);
        n_tests++; if (replaying !== 1'b1 || rp_valid !== 1'b1) begin n_fail++; $display("FAIL nak_start got %b%b want 11", replaying, rp_valid); end
        n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL nak_purge got %0d want 3", count); end
        n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL nak_wr_ready got %b want 0", wr_ready); end
        for (int i = 1; i <= 3; i++) begin
            n_tests++;
            if (rp_seq !== 12'(i) || rp_data !== 16'hB000 + 16'(i)) begin
                n_fail++; $display("FAIL nak_word%0d got seq=%0d data=%h want %0d/%h", i, rp_seq, rp_data, i, 16'hB000 + 16'(i));
            end
            tick();
        end
        n_tests++; if (replaying !== 1'b0 || rp_valid !== 1'b0) begin n_fail++; $display("FAIL nak_end got %b%b want 00", replaying, rp_valid); end
        pulse_timer();
        busy_n = 1'b0;
        n_tests++; if (replaying !== 1'b1 || rp_seq !== 12'd1) begin n_fail++; $display("FAIL tim_start got rep=%b seq=%0d want 1/1", replaying, rp_seq); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (rp_data !== 16'hB001) begin n_fail++; $display("FAIL hold%0d got %h want b001", i, rp_data); end
        end
        busy_n = 1'b1;
        tick();
        n_tests++; if (rp_data !== 16'hB002 || rp_seq !== 12'd2) begin n_fail++; $display("FAIL resume got %h/%0d want b002/2", rp_data, rp_seq); end
        tick();
        tick();
        n_tests++; if (replaying !== 1'b0 || count !== 5'd3) begin n_fail++; $display("FAIL resume_end got rep=%b count=%0d want 0/3", replaying, count); end
    endtask

    task automatic test_rollover();
        do_reset();
        write_word(16'h2000);
        write_word(16'h2001);
        busy_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse_timer();
            n_tests++; if (replaying !== 1'b1 || rollover !== 1'b0) begin n_fail++; $display("FAIL roll_replay%0d got rep=%b roll=%b want 1/0", k, replaying, rollover); end
            tick();
            tick();
            n_tests++; if (replaying !== 1'b0) begin n_fail++; $display("FAIL roll_done%0d got %b want 0", k, replaying); end
        end
        pulse_timer();
        n_tests++; if (replaying !== 1'b0 || rollover !== 1'b1) begin n_fail++; $display("FAIL roll_pulse got rep=%b roll=%b want 0/1", replaying, rollover); end
        tick();
        n_tests++; if (rollover !== 1'b0) begin n_fail++; $display("FAIL roll_one_cycle got %b want 0", rollover); end
        // REPLAY_NUM is back to 0, so the next expiry replays again
        pulse_timer();
        n_tests++; if (replaying !== 1'b1 || rollover !== 1'b0 || rp_seq !== 12'd0) begin n_fail++; $display("FAIL roll_after got rep=%b roll=%b seq=%0d want 1/0/0", replaying, rollover, rp_seq); end
        tick();
        tick();
    endtask

    task automatic test_seq_err_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) write_word(16'h3000 + 16'(i));
        send_dllp(2'b01, 12'd1);
        n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL err_setup got %0d want 3", count); end
        send_dllp(2'b01, 12'd9);
        n_tests++; if (seq_err !== 1'b1 || count !== 5'd3 || replaying !== 1'b0) begin n_fail++; $display("FAIL err_ack got err=%b count=%0d rep=%b want 1/3/0", seq_err, count, replaying); end
        send_dllp(2'b10, 12'd9);
        n_tests++; if (seq_err !== 1'b1 || replaying !== 1'b0 || count !== 5'd3) begin n_fail++; $display("FAIL err_nak got err=%b rep=%b count=%0d want 1/0/3", seq_err, replaying, count); end
        send_dllp(2'b01, 12'd4);
        for (int s = 5; s < 4094; s++) begin
            write_word(16'h4000);
            send_dllp(2'b01, 12'(s));
        end
        n_tests++; if (wr_seq !== 12'd4094 || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_pre got seq=%0d empty=%b want 4094/1", wr_seq, empty); end
        for (int i = 0; i < 4; i++) write_word(16'h5000 + 16'(i));
        n_tests++; if (wr_seq !== 12'd2 || count !== 5'd4) begin n_fail++; $display("FAIL wrap_seq got seq=%0d count=%0d want 2/4", wr_seq, count); end
        send_dllp(2'b01, 12'd0);
        n_tests++; if (count !== 5'd1 || seq_err !== 1'b0) begin n_fail++; $display("FAIL wrap_ack got count=%0d err=%b want 1/0", count, seq_err); end
        send_dllp(2'b10, 12'd0);
        n_tests++; if (replaying !== 1'b1 || rp_seq !== 12'd1 || rp_data !== 16'h5003) begin n_fail++; $display("FAIL wrap_replay got rep=%b seq=%0d data=%h want 1/1/5003", replaying, rp_seq, rp_data); end
        tick();
        n_tests++; if (replaying !== 1'b0) begin n_fail++; $display("FAIL wrap_end got %b want 0", replaying); end
    endtask

    task automatic test_ack_during_replay();
        do_reset();
        for (int i = 0; i < 6; i++) write_word(16'hC000 + 16'(i));
        busy_n = 1'b0;
        pulse_timer();
        n_tests++; if (replaying !== 1'b1 || rp_seq !== 12'd0) begin n_fail++; $display("FAIL snap_start got rep=%b seq=%0d want 1/0", replaying, rp_seq); end
        send_dllp(2'b01, 12'd2);
        n_tests++; if (rp_seq !== 12'd3 || rp_data !== 16'hC003 || count !== 5'd3) begin n_fail++; $display("FAIL snap_jump got seq=%0d data=%h count=%0d want 3/c003/3", rp_seq, rp_data, count); end
        n_tests++; if (replaying !== 1'b1) begin n_fail++; $display("FAIL snap_still got %b want 1", replaying); end
        busy_n = 1'b1;
        tick();
        n_tests++; if (rp_seq !== 12'd4) begin n_fail++; $display("FAIL snap_adv got %0d want 4", rp_seq); end
        busy_n = 1'b0;
        send_dllp(2'b01, 12'd5);
        n_tests++; if (replaying !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL snap_empty got rep=%b empty=%b want 0/1", replaying, empty); end
        busy_n = 1'b1;
        write_word(16'hE000);
        write_word(16'hE001);
        busy_n = 1'b0;
        pulse_timer();
        n_tests++; if (replaying !== 1'b1) begin n_fail++; $display("FAIL rst_mid_start got %b want 1", replaying); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (replaying !== 1'b0 || rp_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state got rep=%b vld=%b count=%0d empty=%b want 0/0/0/1", replaying, rp_valid, count, empty); end
        n_tests++; if (wr_seq !== 12'd0 || wr_ready !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr got seq=%0d rdy=%b full=%b want 0/1/0", wr_seq, wr_ready, full); end
        busy_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ack_purge();
        test_full();
        test_nak_replay();
        test_rollover();
        test_seq_err_wrap();
        test_ack_during_replay();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
